pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/cpu_ctrl_pkg.sv | 25 ++
 rtl/pipe_hazard_ctrl_if.sv | 43 ++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM encodings, NOP word, register-zero
// constant and the per-stage RAW match helper.
package cpu_ctrl_pkg;

   localparam int unsigned REG_W   = 5;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned STATE_W = 2;

   localparam logic [INSTR_W-1:0] NOP      = 32'h0000_0000;
   localparam logic [REG_W-1:0]   REG_ZERO = 5'd0;

   typedef enum logic [STATE_W-1:0] {
      RUN        = 2'd0,
      CT_WAIT    = 2'd1,
      RESET_HOLD = 2'd2
   } ctrl_state_e;

   // A downstream stage will write src and has not yet done so (no write-through).
   function automatic logic stage_hit(input logic [REG_W-1:0] src,
                                      input logic             regwr,
                                      input logic [REG_W-1:0] regaw);
      return regwr && (regaw == src);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM/WB observations in, pipeline enables out.
interface pipe_hazard_ctrl_if
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 16
);
   logic [REG_W-1:0]   id_rs;
   logic [REG_W-1:0]   id_rt;
   logic               id_uses_rs;
   logic               id_uses_rt;
   logic               id_is_ct;
   logic               ex_regwr;
   logic               mem_regwr;
   logic               wb_regwr;
   logic [REG_W-1:0]   ex_regaw;
   logic [REG_W-1:0]   mem_regaw;
   logic [REG_W-1:0]   wb_regaw;
   logic               mem_redirect;

   logic               pc_en;
   logic               ifid_en;
   logic               ifid_flush;
   logic               idex_bubble;
   logic [STATE_W-1:0] state;
   logic [CNT_W-1:0]   stall_cnt;
   logic [CNT_W-1:0]   redirect_cnt;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_ct,
             ex_regwr, mem_regwr, wb_regwr, ex_regaw, mem_regaw, wb_regaw,
             mem_redirect,
      input  pc_en, ifid_en, ifid_flush, idex_bubble, state,
             stall_cnt, redirect_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_ct,
             ex_regwr, mem_regwr, wb_regwr, ex_regaw, mem_regaw, wb_regaw,
             mem_redirect,
      output pc_en, ifid_en, ifid_flush, idex_bubble, state,
             stall_cnt, redirect_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational RAW hazard detection for the instruction sitting in ID.
module hazard_detect
   import cpu_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_regwr,
   input  logic [REG_W-1:0] ex_regaw,
   input  logic             mem_regwr,
   input  logic [REG_W-1:0] mem_regaw,
   input  logic             wb_regwr,
   input  logic [REG_W-1:0] wb_regaw,
   output logic             hazard_c
);

   logic rs_pending_c;
   logic rt_pending_c;

   // r0 is hardwired, so it can never be pending.
   always_comb begin
      rs_pending_c = id_uses_rs && (id_rs != REG_ZERO) &&
                     (stage_hit(id_rs, ex_regwr,  ex_regaw)  ||
                      stage_hit(id_rs, mem_regwr, mem_regaw) ||
                      stage_hit(id_rs, wb_regwr,  wb_regaw));
      rt_pending_c = id_uses_rt && (id_rt != REG_ZERO) &&
                     (stage_hit(id_rt, ex_regwr,  ex_regaw)  ||
                      stage_hit(id_rt, mem_regwr, mem_regaw) ||
                      stage_hit(id_rt, wb_regwr,  wb_regaw));
      hazard_c     = rs_pending_c || rt_pending_c;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW stalls, control-transfer squash sequencing,
// reset hold and saturating stall/redirect performance counters.
module pipe_hazard_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 16
)(
   input  logic              clk,
   input  logic              reset,
   pipe_hazard_ctrl_if.slave bus
);

   ctrl_state_e      state_q;
   ctrl_state_e      state_d;
   logic             wait_q;
   logic             wait_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] redirect_cnt_q;

   logic hazard_c;
   logic pc_en_c;
   logic ifid_en_c;
   logic ifid_flush_c;
   logic idex_bubble_c;
   logic redirect_hit_c;

   hazard_detect u_hazard_detect (
      .id_rs      (bus.id_rs),
      .id_rt      (bus.id_rt),
      .id_uses_rs (bus.id_uses_rs),
      .id_uses_rt (bus.id_uses_rt),
      .ex_regwr   (bus.ex_regwr),
      .ex_regaw   (bus.ex_regaw),
      .mem_regwr  (bus.mem_regwr),
      .mem_regaw  (bus.mem_regaw),
      .wb_regwr   (bus.wb_regwr),
      .wb_regaw   (bus.wb_regaw),
      .hazard_c   (hazard_c)
   );

   // State, wait counter and performance counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= RESET_HOLD;
         wait_q         <= 1'b0;
         stall_cnt_q    <= '0;
         redirect_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (!pc_en_c && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (redirect_hit_c && (redirect_cnt_q != '1))
            redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
      end
   end

   // Next-state and pipeline-enable decode; outputs follow inputs in the same cycle.
   always_comb begin
      state_d        = state_q;
      wait_d         = wait_q;
      pc_en_c        = 1'b0;
      ifid_en_c      = 1'b1;
      ifid_flush_c   = 1'b0;
      idex_bubble_c  = 1'b0;
      redirect_hit_c = 1'b0;

      if (reset) begin
         ifid_flush_c  = 1'b1;
         idex_bubble_c = 1'b1;
         state_d       = RESET_HOLD;
         wait_d        = 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (hazard_c) begin
                  ifid_en_c     = 1'b0;
                  idex_bubble_c = 1'b1;
               end else if (bus.id_is_ct) begin
                  ifid_flush_c = 1'b1;
                  state_d      = CT_WAIT;
                  wait_d       = 1'b1;
               end else begin
                  pc_en_c = 1'b1;
               end
            end
            CT_WAIT: begin
               // ID holds a squashed NOP here, so hazard and id_is_ct are don't-care.
               if (wait_q) begin
                  ifid_flush_c = 1'b1;
                  wait_d       = 1'b0;
               end else begin
                  pc_en_c        = 1'b1;
                  ifid_flush_c   = bus.mem_redirect;
                  redirect_hit_c = bus.mem_redirect;
                  state_d        = RUN;
               end
            end
            RESET_HOLD: begin
               pc_en_c       = 1'b1;
               ifid_flush_c  = 1'b1;
               idex_bubble_c = 1'b1;
               state_d       = RUN;
            end
            default: begin
               ifid_en_c     = 1'b0;
               idex_bubble_c = 1'b1;
               state_d       = RUN;
               wait_d        = 1'b0;
            end
         endcase
      end
   end

   assign bus.pc_en        = pc_en_c;
   assign bus.ifid_en      = ifid_en_c;
   assign bus.ifid_flush   = ifid_flush_c;
   assign bus.idex_bubble  = idex_bubble_c;
   assign bus.state        = state_q;
   assign bus.stall_cnt    = stall_cnt_q;
   assign bus.redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl: per-cycle table plus hand-written
// reset, branch and counter-saturation sequences.
module tb_pipe_hazard_ctrl;

   typedef struct {
      logic       rst;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic       ct;
      logic       exw;
      logic [4:0] exa;
      logic       mw;
      logic [4:0] ma;
      logic       ww;
      logic [4:0] wa;
      logic       redir;
      logic [3:0] exp_o;   // {pc_en, ifid_en, ifid_flush, idex_bubble}
      logic [1:0] exp_st;
   } vec_t;

   localparam int NVEC = 20;

   logic clk = 1'b0;
   logic reset;
   int   n_total = 0;
   int   n_pass  = 0;
   vec_t tbl [NVEC];

   pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();

   pipe_hazard_ctrl #(.CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic rst, logic [4:0] rs, logic [4:0] rt,
                               logic urs, logic urt, logic ct,
                               logic exw, logic [4:0] exa, logic mw, logic [4:0] ma,
                               logic ww, logic [4:0] wa, logic redir,
                               logic [3:0] exp_o, logic [1:0] exp_st);
      vec_t v;
      v.rst = rst; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.ct = ct;
      v.exw = exw; v.exa = exa; v.mw = mw; v.ma = ma; v.ww = ww; v.wa = wa;
      v.redir = redir; v.exp_o = exp_o; v.exp_st = exp_st;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      reset            = v.rst;
      bus.id_rs        = v.rs;
      bus.id_rt        = v.rt;
      bus.id_uses_rs   = v.urs;
      bus.id_uses_rt   = v.urt;
      bus.id_is_ct     = v.ct;
      bus.ex_regwr     = v.exw;
      bus.ex_regaw     = v.exa;
      bus.mem_regwr    = v.mw;
      bus.mem_regaw    = v.ma;
      bus.wb_regwr     = v.ww;
      bus.wb_regaw     = v.wa;
      bus.mem_redirect = v.redir;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else
         n_pass++;
   endtask

   function automatic logic [31:0] outs();
      return 32'({bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble});
   endfunction

   task automatic do_reset();
      drive(mk(1, 0,0,0,0,0, 0,0,0,0,0,0, 0, 4'b0, 2'd0));
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      tbl[0]  = mk(1, 0,0,0,0,0, 0,0,0,0,0,0, 0, 4'b0111, 2'd2);
      tbl[1]  = mk(0, 0,0,0,0,0, 0,0,0,0,0,0, 0, 4'b1111, 2'd2);
      tbl[2]  = mk(0, 0,0,0,0,0, 0,0,0,0,0,0, 0, 4'b1100, 2'd0);
      tbl[3]  = mk(0, 0,0,1,0,0, 1,0,0,0,0,0, 0, 4'b1100, 2'd0);
      tbl[4]  = mk(0, 5,0,1,0,0, 1,5,0,0,0,0, 0, 4'b0001, 2'd0);
      tbl[5]  = mk(0, 5,0,1,0,0, 0,0,1,5,0,0, 0, 4'b0001, 2'd0);
      tbl[6]  = mk(0, 5,0,1,0,0, 0,0,0,0,1,5, 0, 4'b0001, 2'd0);
      tbl[7]  = mk(0, 5,0,1,0,0, 0,0,0,0,0,0, 0, 4'b1100, 2'd0);
      tbl[8]  = mk(0, 0,9,0,0,0, 1,9,0,0,0,0, 0, 4'b1100, 2'd0);
      tbl[9]  = mk(0, 0,9,0,1,0, 0,9,0,0,0,0, 0, 4'b1100, 2'd0);
      tbl[10] = mk(0, 3,4,1,1,0, 0,0,0,0,1,4, 0, 4'b0001, 2'd0);
      tbl[11] = mk(0, 2,0,1,0,1, 0,0,1,2,0,0, 0, 4'b0001, 2'd0);
      tbl[12] = mk(0, 0,0,0,0,1, 0,0,0,0,0,0, 0, 4'b0110, 2'd0);
      tbl[13] = mk(0, 5,0,1,0,1, 1,5,0,0,0,0, 0, 4'b0110, 2'd1);
      tbl[14] = mk(0, 0,0,0,0,0, 0,0,0,0,0,0, 1, 4'b1110, 2'd1);
      tbl[15] = mk(0, 0,0,0,0,0, 0,0,0,0,0,0, 0, 4'b1100, 2'd0);
      tbl[16] = mk(0, 0,0,0,0,1, 0,0,0,0,0,0, 0, 4'b0110, 2'd0);
      tbl[17] = mk(0, 0,0,0,0,1, 0,0,0,0,0,0, 0, 4'b0110, 2'd1);
      tbl[18] = mk(0, 0,0,0,0,0, 0,0,0,0,0,0, 0, 4'b1100, 2'd1);
      tbl[19] = mk(0, 0,0,0,0,0, 0,0,0,0,0,0, 0, 4'b1100, 2'd0);

      // Table: one row per cycle, continuous from a first reset edge.
      drive(mk(1, 0,0,0,0,0, 0,0,0,0,0,0, 0, 4'b0, 2'd0));
      tick();
      for (int i = 0; i < NVEC; i++) begin
         drive(tbl[i]);
         #1;
         chk($sformatf("vec%0d_outs", i), outs(), 32'(tbl[i].exp_o));
         chk($sformatf("vec%0d_state", i), 32'(bus.state), 32'(tbl[i].exp_st));
         tick();
      end
      chk("tbl_stall_cnt", 32'(bus.stall_cnt), 32'd9);
      chk("tbl_redirect_cnt", 32'(bus.redirect_cnt), 32'd1);

      // Producer of r5 walks EX -> MEM -> WB: exactly three stall cycles.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(mk(0, 5,0,1,0,0, k==0,5, k==1,5, k==2,5, 0, 4'b0, 2'd0));
         #1;
         chk($sformatf("raw_stall%0d", k), outs(), 32'b0001);
         tick();
      end
      drive(mk(0, 5,0,1,0,0, 0,0,0,0,0,0, 0, 4'b0, 2'd0));
      #1;
      chk("raw_release", outs(), 32'b1100);
      tick();
      chk("raw_stall_cnt", 32'(bus.stall_cnt), 32'd3);

      // Branch waiting on r7 from MEM: two stalls, then taken CT sequence.
      do_reset();
      drive(mk(0, 0,7,0,1,1, 0,0,1,7,0,0, 0, 4'b0, 2'd0));
      #1; chk("br_stall0", outs(), 32'b0001); tick();
      drive(mk(0, 0,7,0,1,1, 0,0,0,0,1,7, 0, 4'b0, 2'd0));
      #1; chk("br_stall1", outs(), 32'b0001); tick();
      drive(mk(0, 0,7,0,1,1, 0,0,0,0,0,0, 0, 4'b0, 2'd0));
      #1; chk("br_ct0", outs(), 32'b0110); tick();
      drive(mk(0, 0,0,0,0,0, 0,0,0,0,0,0, 0, 4'b0, 2'd0));
      #1; chk("br_ct1", outs(), 32'b0110); tick();
      drive(mk(0, 0,0,0,0,0, 0,0,0,0,0,0, 1, 4'b0, 2'd0));
      #1; chk("br_ct2", outs(), 32'b1110); tick();
      drive(mk(0, 0,0,0,0,0, 0,0,0,0,0,0, 0, 4'b0, 2'd0));
      #1;
      chk("br_state", 32'(bus.state), 32'd0);
      chk("br_stall_cnt", 32'(bus.stall_cnt), 32'd4);
      chk("br_redirect_cnt", 32'(bus.redirect_cnt), 32'd1);
      tick();

      // Reset during the first CT_WAIT cycle abandons the transfer.
      do_reset();
      drive(mk(0, 0,0,0,0,1, 0,0,0,0,0,0, 0, 4'b0, 2'd0));
      #1; tick();
      drive(mk(1, 0,0,0,0,0, 0,0,0,0,0,0, 1, 4'b0, 2'd0));
      #1;
      chk("rst_ct_state_before", 32'(bus.state), 32'd1);
      chk("rst_ct_outs", outs(), 32'b0111);
      tick();
      drive(mk(0, 0,0,0,0,0, 0,0,0,0,0,0, 1, 4'b0, 2'd0));
      #1;
      chk("rst_hold_state", 32'(bus.state), 32'd2);
      chk("rst_hold_outs", outs(), 32'b1111);
      chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
      chk("rst_redirect_cnt", 32'(bus.redirect_cnt), 32'd0);
      tick();
      drive(mk(0, 0,0,0,0,0, 0,0,0,0,0,0, 0, 4'b0, 2'd0));
      #1;
      chk("rst_run_state", 32'(bus.state), 32'd0);
      chk("rst_run_outs", outs(), 32'b1100);
      tick();
      chk("rst_redirect_cnt_after", 32'(bus.redirect_cnt), 32'd0);

      // Long forced stall drives stall_cnt into saturation.
      do_reset();
      drive(mk(0, 5,0,1,0,0, 1,5,0,0,0,0, 0, 4'b0, 2'd0));
      repeat (65534) tick();
      chk("sat_below", 32'(bus.stall_cnt), 32'hFFFE);
      tick();
      chk("sat_reach", 32'(bus.stall_cnt), 32'hFFFF);
      repeat (5) tick();
      chk("sat_hold", 32'(bus.stall_cnt), 32'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
